// File: rtl/idct_pkg.sv
// Shared definitions for the 8x8 inverse DCT: default widths, Q.12 cosine table,
// FSM state type and the round-half-up / saturate helper used by the 1-D engine.
package idct_pkg;

    localparam int IDCT_DATA_W  = 13;
    localparam int IDCT_CONST_W = 14;
    localparam int IDCT_FRAC    = 12;
    localparam int IDCT_MID_W   = 16;

    typedef logic signed [IDCT_CONST_W-1:0] idct_const_t;

    // IDCT_C[u][x] = round(4096 * 0.5 * c(u) * cos((2x+1)*u*pi/16)), c(0) = 1/sqrt(2)
    localparam int IDCT_C [8][8] = '{
        '{1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448},
        '{2009,  1703,  1138,   400,  -400, -1138, -1703, -2009},
        '{1892,   784,  -784, -1892, -1892,  -784,   784,  1892},
        '{1703,  -400, -2009, -1138,  1138,  2009,   400, -1703},
        '{1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448},
        '{1138, -2009,   400,  1703, -1703,  -400,  2009, -1138},
        '{ 784, -1892,  1892,  -784,  -784,  1892, -1892,   784},
        '{ 400, -1138,  1703, -2009,  2009, -1703,  1138,  -400}
    };

    typedef enum logic [1:0] {LOAD, ROW, COL, OUT} idct_state_t;

    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int sat_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (IDCT_FRAC - 1))) >>> IDCT_FRAC;
        hi = (64'sd1 <<< (sat_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/idct_1d.sv
// 8-point combinational inverse DCT: dout[x] = sat(round(sum_u C[u][x] * din[u])).
// Shared by the row and column passes of idct_8x8.
module idct_1d
    import idct_pkg::*;
#(
    parameter int IN_W  = IDCT_MID_W,
    parameter int SAT_W = IDCT_MID_W
) (
    input  logic [7:0][IN_W-1:0]  din,
    output logic [7:0][SAT_W-1:0] dout
);

    // Full-precision products plus 3 guard bits for the 8-term sum
    localparam int ACC_W = IN_W + IDCT_CONST_W + 3;

    always_comb begin
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] a;
        logic signed [ACC_W-1:0] c;
        acc  = '0;
        a    = '0;
        c    = '0;
        dout = '0;
        for (int x = 0; x < 8; x++) begin
            acc = '0;
            for (int u = 0; u < 8; u++) begin
                a   = ACC_W'(signed'(din[u]));
                c   = ACC_W'(idct_const_t'(IDCT_C[u][x]));
                acc = acc + a * c;
            end
            dout[x] = SAT_W'(round_sat(64'(acc), SAT_W));
        end
    end

endmodule

// File: rtl/idct_8x8.sv
// Streaming 8x8 inverse DCT, row then column pass on one shared idct_1d engine.
// Define IDCT_CLAMP_EN for +128 level-shifted pixels clamped to [0,255].
module idct_8x8
    import idct_pkg::*;
#(
    parameter int DATA_W = IDCT_DATA_W,
    parameter int MID_W  = IDCT_MID_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [DATA_W-1:0] coef_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_last,
    output logic              busy
);

    idct_state_t state;
    logic [5:0]  in_cnt;
    logic [5:0]  out_cnt;
    logic [2:0]  pass_cnt;
    logic        coef_fire;

    logic [DATA_W-1:0] coef_buf [64];
    logic [MID_W-1:0]  tp_buf   [8][8];
    logic [DATA_W-1:0] out_buf  [64];

    logic [7:0][MID_W-1:0]  eng_in;
    logic [7:0][MID_W-1:0]  eng_out;
    logic [7:0][DATA_W-1:0] col_pix;

    assign coef_fire = coef_valid && coef_ready;

    // ROW feeds coefficient row pass_cnt; COL feeds transpose-buffer column pass_cnt
    always_comb begin
        eng_in = '0;
        for (int u = 0; u < 8; u++) begin
            if (state == ROW) begin
                eng_in[u] = MID_W'(signed'(coef_buf[{pass_cnt, 3'(u)}]));
            end else begin
                eng_in[u] = tp_buf[u][pass_cnt];
            end
        end
    end

    idct_1d #(
        .IN_W  (MID_W),
        .SAT_W (MID_W)
    ) u_engine (
        .din  (eng_in),
        .dout (eng_out)
    );

`ifdef IDCT_CLAMP_EN
    always_comb begin
        logic signed [MID_W:0] w;
        w       = '0;
        col_pix = '0;
        for (int x = 0; x < 8; x++) begin
            w = (MID_W+1)'(signed'(eng_out[x])) + (MID_W+1)'(128);
            if (w < 0) begin
                col_pix[x] = '0;
            end else if (w > 255) begin
                col_pix[x] = DATA_W'(255);
            end else begin
                col_pix[x] = DATA_W'(w[7:0]);
            end
        end
    end
`else
    localparam int PIX_MAX = 2 ** (DATA_W - 1) - 1;
    localparam int PIX_MIN = -(2 ** (DATA_W - 1));

    always_comb begin
        logic signed [MID_W-1:0] v;
        v       = '0;
        col_pix = '0;
        for (int x = 0; x < 8; x++) begin
            v = signed'(eng_out[x]);
            if (v > PIX_MAX) begin
                col_pix[x] = DATA_W'(PIX_MAX);
            end else if (v < PIX_MIN) begin
                col_pix[x] = DATA_W'(PIX_MIN);
            end else begin
                col_pix[x] = DATA_W'(v);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            in_cnt     <= '0;
            out_cnt    <= '0;
            pass_cnt   <= '0;
            coef_ready <= 1'b0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    coef_ready <= 1'b1;
                    if (coef_fire) begin
                        in_cnt <= in_cnt + 6'd1;
                        if (in_cnt == 6'd63) begin
                            state      <= ROW;
                            coef_ready <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                end
                ROW: begin
                    pass_cnt <= pass_cnt + 3'd1;
                    if (pass_cnt == 3'd7) state <= COL;
                end
                COL: begin
                    pass_cnt <= pass_cnt + 3'd1;
                    if (pass_cnt == 3'd7) state <= OUT;
                end
                OUT: begin
                    if (pix_valid && pix_ready && pix_last) begin
                        pix_valid  <= 1'b0;
                        pix_last   <= 1'b0;
                        state      <= LOAD;
                        coef_ready <= 1'b1;
                        busy       <= 1'b0;
                    end else if (!pix_valid || pix_ready) begin
                        // First OUT cycle primes the output register, later ones advance
                        pix_valid <= 1'b1;
                        pix_data  <= out_buf[out_cnt];
                        pix_last  <= (out_cnt == 6'd63);
                        out_cnt   <= out_cnt + 6'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && coef_fire) begin
            coef_buf[in_cnt] <= coef_data;
        end
        if (state == ROW) begin
            for (int v = 0; v < 8; v++) begin
                tp_buf[pass_cnt][v] <= eng_out[v];
            end
        end
        if (state == COL) begin
            for (int x = 0; x < 8; x++) begin
                out_buf[{3'(x), pass_cnt}] <= col_pix[x];
            end
        end
    end

endmodule

// File: tb/tb_idct_8x8.sv
// Bench for idct_8x8: directed DC/saturation/backpressure/reset cases plus random
// blocks against a bench-side fixed-point IDCT whose constants come from $cos.
`timescale 1ns/1ps
module tb_idct_8x8;

    localparam int DATA_W = 13;
    typedef int blk_t [64];

`ifdef IDCT_CLAMP_EN
    localparam int DC_EXP  = 136;
    localparam int NEG_EXP = 0;
    localparam int SAT_EXP = 255;
    localparam int BIG_EXP = 255;
`else
    localparam int DC_EXP  = 8;
    localparam int NEG_EXP = -128;
    localparam int SAT_EXP = 512;
    localparam int BIG_EXP = 4095;
`endif

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              coef_valid = 1'b0;
    logic              pix_ready  = 1'b0;
    logic [DATA_W-1:0] coef_data  = '0;
    logic              coef_ready;
    logic              pix_valid;
    logic              pix_last;
    logic              busy;
    logic [DATA_W-1:0] pix_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cmat [8][8];

    idct_8x8 dut (
        .clk        (clk),
        .reset      (reset),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int pix_to_int(input logic [DATA_W-1:0] d);
`ifdef IDCT_CLAMP_EN
        return int'(d);
`else
        return int'($signed(d));
`endif
    endfunction

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic init_cmat();
        real pi;
        real s;
        pi = 3.14159265358979323846;
        for (int u = 0; u < 8; u++) begin
            s = (u == 0) ? 0.5 / $sqrt(2.0) : 0.5;
            for (int x = 0; x < 8; x++) begin
                cmat[u][x] = $rtoi($floor(4096.0 * s * $cos(real'((2 * x + 1) * u) * pi / 16.0)
                                          + 0.5));
            end
        end
    endtask

    task automatic model(input blk_t c, output blk_t e);
        longint mid [8][8];
        longint acc;
        longint v;
        for (int r = 0; r < 8; r++) begin
            for (int y = 0; y < 8; y++) begin
                acc = 0;
                for (int k = 0; k < 8; k++) acc += longint'(c[r * 8 + k]) * cmat[k][y];
                mid[r][y] = clampl((acc + 2048) >>> 12, -32768, 32767);
            end
        end
        for (int col = 0; col < 8; col++) begin
            for (int x = 0; x < 8; x++) begin
                acc = 0;
                for (int u = 0; u < 8; u++) acc += mid[u][col] * cmat[u][x];
                v = (acc + 2048) >>> 12;
`ifdef IDCT_CLAMP_EN
                v = clampl(v + 128, 0, 255);
`else
                v = clampl(v, -4096, 4095);
`endif
                e[x * 8 + col] = int'(v);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the last accepted coefficient.
    task automatic send_block(input blk_t c, input int count);
        int waitc;
        for (int i = 0; i < count; i++) begin
            coef_valid = 1'b1;
            coef_data  = DATA_W'(c[i]);
            waitc = 0;
            while (coef_ready !== 1'b1 && waitc < 500) begin
                @(negedge clk);
                waitc++;
            end
            if (waitc >= 500) begin
                n_checks++;
                n_fail++;
                $display("FAIL coef_ready_timeout: coef %0d not accepted within 500 cycles", i);
                coef_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        coef_valid = 1'b0;
    endtask

    task automatic recv_block(input int bp, output blk_t got);
        int   cyc;
        int   ngot;
        bit   hold_v;
        logic [DATA_W-1:0] hold_d;
        logic hold_l;
        bit   stable_ok;
        bit   last_ok;
        bit   refuse_ok;
        ngot = 0; cyc = 0; hold_v = 0; hold_d = '0; hold_l = 1'b0;
        stable_ok = 1; last_ok = 1; refuse_ok = 1;
        for (int i = 0; i < 64; i++) got[i] = 0;
        coef_valid = 1'b1;
        coef_data  = DATA_W'(777);
        while (ngot < 64 && cyc < 3000) begin
            pix_ready = (bp == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (coef_ready !== 1'b0) refuse_ok = 0;
            if (hold_v && (pix_valid !== 1'b1 || pix_data !== hold_d || pix_last !== hold_l))
                stable_ok = 0;
            hold_v = (pix_valid === 1'b1) && !pix_ready;
            hold_d = pix_data;
            hold_l = pix_last;
            if (pix_valid === 1'b1 && pix_ready) begin
                got[ngot] = pix_to_int(pix_data);
                if (pix_last !== (ngot == 63)) last_ok = 0;
                ngot++;
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (ngot != 64) begin
            n_fail++;
            $display("FAIL sample_count: got %0d samples, required 64", ngot);
        end
        n_checks++;
        if (!last_ok) begin
            n_fail++;
            $display("FAIL pix_last: asserted on wrong sample, required only on sample 64");
        end
        n_checks++;
        if (!stable_ok) begin
            n_fail++;
            $display("FAIL stall_stable: data/last changed while stalled, required stable");
        end
        n_checks++;
        if (!refuse_ok) begin
            n_fail++;
            $display("FAIL coef_refused: coef_ready=1 before output done, required 0");
        end
        n_checks++;
        if (coef_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_load: coef_ready=%b pix_valid=%b busy=%b, required 1 0 0",
                     coef_ready, pix_valid, busy);
        end
        coef_valid = 1'b0;
        pix_ready  = 1'b0;
    endtask

    task automatic run_block(input blk_t c, input int bp, output blk_t got);
        int lat;
        send_block(c, 64);
        n_checks++;
        if (busy !== 1'b1 || coef_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_load: busy=%b coef_ready=%b, required 1 0",
                     busy, coef_ready);
        end
        lat = 0;
        while (pix_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 17) begin
            n_fail++;
            $display("FAIL latency: pix_valid after %0d cycles, required 17", lat);
        end
        recv_block(bp, got);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (coef_ready !== 1'b0 || pix_valid !== 1'b0 || pix_data !== '0 ||
            pix_last !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b valid=%b data=%0d last=%b busy=%b, required 0",
                     coef_ready, pix_valid, pix_data, pix_last, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (coef_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_reset: coef_ready=%b busy=%b, required 1 0",
                     coef_ready, busy);
        end
    endtask

    task automatic test_const_block(input string name, input int dc, input int expv,
                                    input int bp);
        blk_t c;
        blk_t got;
        int   bad;
        for (int i = 0; i < 64; i++) c[i] = 0;
        c[0] = dc;
        run_block(c, bp, got);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (got[i] !== expv) begin
                n_fail++;
                bad++;
                if (bad <= 4)
                    $display("FAIL %s sample %0d: got %0d, required %0d", name, i, got[i], expv);
            end
        end
    endtask

    task automatic test_big_saturation();
        blk_t c;
        blk_t e;
        blk_t got;
        for (int i = 0; i < 64; i++) c[i] = 2047;
        model(c, e);
        run_block(c, 0, got);
        n_checks++;
        if (got[0] !== BIG_EXP) begin
            n_fail++;
            $display("FAIL big_sat sample 0: got %0d, required %0d", got[0], BIG_EXP);
        end
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (got[i] !== e[i]) begin
                n_fail++;
                $display("FAIL big_sat sample %0d: got %0d, required %0d", i, got[i], e[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        blk_t junk;
        for (int i = 0; i < 64; i++) junk[i] = 1000 + i;
        send_block(junk, 30);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (coef_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_load_ready: coef_ready=%b, required 0", coef_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_const_block("reset_load_dc", 64, DC_EXP, 0);
    endtask

    task automatic test_reset_mid_out();
        blk_t c;
        int   waitc;
        for (int i = 0; i < 64; i++) c[i] = 0;
        c[0] = 64;
        send_block(c, 64);
        waitc = 0;
        while (pix_valid !== 1'b1 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || waitc >= 100) begin
            n_fail++;
            $display("FAIL reset_out: pix_valid=%b busy=%b wait=%0d, required 0 0 <100",
                     pix_valid, busy, waitc);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random(input int nblk);
        blk_t c;
        blk_t e;
        blk_t got;
        int   bad;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 64; i++) c[i] = int'($urandom_range(4095)) - 2048;
            model(c, e);
            run_block(c, b % 2, got);
            bad = 0;
            for (int i = 0; i < 64; i++) begin
                n_checks++;
                if (got[i] !== e[i]) begin
                    n_fail++;
                    bad++;
                    if (bad <= 4)
                        $display("FAIL random blk %0d sample %0d: got %0d, required %0d",
                                 b, i, got[i], e[i]);
                end
            end
        end
    endtask

    initial begin
        init_cmat();
        test_reset();
        test_const_block("dc", 64, DC_EXP, 0);
        test_const_block("neg_dc", -1024, NEG_EXP, 0);
        test_const_block("sat_dc", 4095, SAT_EXP, 0);
        test_const_block("backpressure_dc", 64, DC_EXP, 1);
        test_big_saturation();
        test_reset_mid_load();
        test_reset_mid_out();
        test_random(16);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
